// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundle between the fetch sequencer and its neighbours.
// master drives the hazard/EX/fetch-side signals, slave is fetch_ctrl.
interface fetch_ctrl_if;
    logic [31:0] pc_cur;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        trap;
    logic        halt_req;
    logic        resume;
    logic [31:0] next_pc;
    logic        if_valid;
    logic        flush;
    logic        halted;
    logic [15:0] stall_cycles;
    logic [15:0] redirect_count;

    modport master (
        output pc_cur, stall, br_taken, br_target,
        output trap, halt_req, resume,
        input  next_pc, if_valid, flush, halted,
        input  stall_cycles, redirect_count
    );

    modport slave (
        input  pc_cur, stall, br_taken, br_target,
        input  trap, halt_req, resume,
        output next_pc, if_valid, flush, halted,
        output stall_cycles, redirect_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: next-PC sequencer for the fetch stage.
// Define FETCH_CTRL_PERF_EN to build the stall/redirect counters.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
    input logic         clk,
    input logic         rst_n,
    fetch_ctrl_if.slave bus
);

    localparam logic [31:0] ALIGN   = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_A = RESET_PC & ALIGN;
    localparam logic [31:0] TRAP_A  = TRAP_PC & ALIGN;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        pend_valid_q;
    logic        pend_valid_d;
    logic [31:0] pend_target_q;
    logic [31:0] pend_target_d;
    logic [31:0] npc;
    logic        flush_c;
    logic        redir;
    logic [31:0] pc_hold;
    logic [31:0] pc_inc;
    logic [31:0] br_aligned;
    logic        active;

    assign pc_hold    = bus.pc_cur & ALIGN;
    assign pc_inc     = pc_hold + 32'd4;
    assign br_aligned = bus.br_target & ALIGN;
    assign active     = (state_q == RUN) || (state_q == HOLD);

    // State and pending-branch registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    // Next-state, next-PC and flush selection; earlier rules win
    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        npc           = pc_hold;
        flush_c       = 1'b0;
        redir         = 1'b0;
        unique case (state_q)
            BOOT: begin
                npc     = RESET_A;
                flush_c = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (bus.trap) begin
                    npc     = TRAP_A;
                    flush_c = 1'b1;
                    redir   = 1'b1;
                end else if (bus.br_taken && !bus.stall) begin
                    npc     = br_aligned;
                    flush_c = 1'b1;
                    redir   = 1'b1;
                end else if (bus.br_taken) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = br_aligned;
                    state_d       = HOLD;
                end else if (bus.halt_req) begin
                    flush_c = 1'b1;
                    state_d = HALT;
                end else if (!bus.stall) begin
                    npc = pc_inc;
                end
            end
            HOLD: begin
                if (bus.trap) begin
                    npc           = TRAP_A;
                    flush_c       = 1'b1;
                    redir         = 1'b1;
                    pend_valid_d  = 1'b0;
                    pend_target_d = '0;
                    state_d       = RUN;
                end else if (bus.stall) begin
                    // youngest branch seen during the stall wins
                    if (bus.br_taken) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = br_aligned;
                    end
                end else begin
                    npc           = pend_valid_q ? pend_target_q : pc_hold;
                    flush_c       = 1'b1;
                    redir         = 1'b1;
                    pend_valid_d  = 1'b0;
                    pend_target_d = '0;
                    state_d       = RUN;
                end
            end
            HALT: begin
                // branches are ignored; the pipe is drained before halting
                if (bus.trap) begin
                    npc     = TRAP_A;
                    flush_c = 1'b1;
                    redir   = 1'b1;
                    state_d = RUN;
                end else if (bus.resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign bus.next_pc  = npc;
    assign bus.flush    = flush_c;
    assign bus.if_valid = active && !bus.stall && !flush_c;
    assign bus.halted   = (state_q == HALT);

`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] redir_cnt_q;

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (active && bus.stall && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (redir && redir_cnt_q != 16'hFFFF)
                redir_cnt_q <= redir_cnt_q + 16'd1;
        end
    end

    assign bus.stall_cycles   = stall_cnt_q;
    assign bus.redirect_count = redir_cnt_q;
`else
    logic perf_unused;

    assign perf_unused        = redir;
    assign bus.stall_cycles   = 16'h0;
    assign bus.redirect_count = 16'h0;
`endif

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Next-PC sequencer for the fetch stage. It picks the PC to load into the IF-stage PC register each cycle from several sources: reset vector, trap vector, taken-branch redirect, stall hold, or sequential +4. It also drives the IF/ID valid and flush controls, latches a branch redirect that arrives during a stall, and supports a halt/resume handshake for debug. It sits between the hazard/EX units and the fetch stage; `next_pc` feeds the fetch stage's next-PC input, and the fetch stage's current PC returns on `pc_cur`.

## Interface
- `RESET_PC`, default 32'h0000_0000: first PC fetched after reset.
- `TRAP_PC`, default 32'h0000_0100: PC loaded on `trap`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `pc_cur`  in  32  current PC held by the fetch stage.
- `stall`  in  1  hazard unit requests that fetch hold.
- `br_taken`  in  1  EX resolved a taken branch or jump this cycle.
- `br_target`  in  32  branch target; bits [1:0] are ignored (forced to 0).
- `trap`  in  1  exception; redirect to `TRAP_PC`.
- `halt_req`  in  1  debug halt request; a level, held until `halted` = 1.
- `resume`  in  1  single-cycle pulse; leave HALT.
- `next_pc`  out  32  PC to load into the fetch PC register at the next edge.
- `if_valid`  out  1  instruction at `pc_cur` is to be captured into IF/ID.
- `flush`  out  1  kill the IF/ID contents this cycle.
- `halted`  out  1  high while the state is HALT.
- `stall_cycles`  out  16  saturating count of cycles with `stall`=1 in RUN/HOLD.
- `redirect_count`  out  16  saturating count of applied redirects.

## Operation
- States: BOOT, RUN, HOLD, HALT. Reset (`rst_n`=0 at an edge) sets BOOT, clears `pend_valid`, `pend_target` and both counters.
- Outputs are combinational from the state, `pend_*` and the inputs. `next_pc` is always word-aligned.
- **BOOT:** `next_pc`=`RESET_PC`, `if_valid`=0, `flush`=1. Always goes to RUN.
- **RUN, first matching rule applies:**
  - `trap`: `next_pc`=`TRAP_PC`, `flush`=1, stay RUN.
  - `br_taken` & !`stall`: `next_pc`={`br_target`[31:2],2'b00}, `flush`=1, stay RUN.
  - `br_taken` & `stall`: latch the aligned target into `pend_target`, set `pend_valid`, `next_pc`=`pc_cur`, `flush`=0, go to HOLD.
  - `halt_req`: `next_pc`=`pc_cur`, `flush`=1, go to HALT.
  - `stall`: `next_pc`=`pc_cur`, `flush`=0.
  - Otherwise: `next_pc`=`pc_cur`+4, with modulo 2^32 wrap (32'hFFFF_FFFC goes to 0).
- **HOLD:**
  - `trap`: `TRAP_PC`, `flush`=1, clear pend, go to RUN.
  - `stall`: hold `pc_cur`. A new `br_taken` overwrites `pend_target`, so the youngest branch wins.
  - !`stall`: `next_pc`=`pend_target`, `flush`=1, clear pend, go to RUN.
- **HALT:**
  - `trap`: `TRAP_PC`, `flush`=1, go to RUN.
  - `resume`: `next_pc`=`pc_cur`, go to RUN; refetch with no flush.
  - Otherwise: hold `pc_cur`, `if_valid`=0.
  - `br_taken` is ignored in HALT; the pipeline is drained before a halt.
- `if_valid` = (state is RUN or HOLD) & !`stall` & !`flush`.
- `redirect_count` increments on every cycle with `flush`=1 caused by a trap or branch (not BOOT or halt entry). Both counters saturate at 16'hFFFF.

## Timing
- Zero-cycle combinational path from `stall`/`br_taken`/`trap` to `next_pc`; the new PC becomes visible on `pc_cur` one edge later.
- A redirect costs exactly one bubble: `flush` is high in the redirect cycle and `if_valid` is 0.
- A branch during a stall is applied in the first cycle `stall` is low.
- `halted` rises one edge after `halt_req` is sampled in RUN. `resume` is taken one cycle after `halted`.
- Reset mid-operation: at the next edge with `rst_n`=0, the state is BOOT and all pending state is discarded. In the cycle after reset deasserts, `next_pc`=`RESET_PC`.

## Configuration
- `FETCH_CTRL_PERF_EN`, when defined: `stall_cycles` and `redirect_count` are implemented as described.
- When undefined: the counter registers are not built and both ports are tied to 16'h0. The port list is unchanged.

## Test plan
- Reset release, no stall: `next_pc` sequence is 0x0, 0x4, 0x8, 0xC. `if_valid` is 0 in the BOOT cycle and 1 afterwards.
- `br_taken`=1, `br_target`=0x43 at `pc_cur`=0x10: `next_pc`=0x40 and `flush`=1 for one cycle, then 0x44. `redirect_count`=1.
- `stall` high for 3 cycles, with `br_taken` (target 0x80) in the 1st cycle and (target 0x90) in the 2nd: PC holds, then `next_pc`=0x90 with `flush`=1 when the stall drops. `stall_cycles`=3.
- `trap` together with `br_taken` and `stall`: `next_pc`=0x100, `flush`=1, any pending branch discarded.
- `halt_req` at `pc_cur`=0x20: `halted`=1 next cycle and the PC holds at 0x20. A `resume` pulse then gives `next_pc`=0x20, followed by 0x24.
- `rst_n`=0 while in HOLD with a pending target: after reset the sequence restarts at 0x0 with no redirect applied. With the macro undefined, the counters read 0.
